// File: rtl/sector_hexdump_if.sv
// sector_hexdump_if
//   Groups the sector byte capture stream, the dump-control handshake and the
//   character output handshake of sector_hexdump.
//   master : upstream / sink side (sector reader + UART), drives inputs to the dumper
//   slave  : the dumper itself
//   Signals: rvalid/raddr/rdata  sector byte stream from the reader
//            done                one-cycle pulse, sector read complete
//            busy                dump in progress
//            dump_done           one-cycle pulse after the final character grant
//            wreq/wgnt/wdata     ASCII character handshake towards the UART
interface sector_hexdump_if;
  logic       rvalid;
  logic [8:0] raddr;
  logic [7:0] rdata;
  logic       done;
  logic       busy;
  logic       dump_done;
  logic       wreq;
  logic       wgnt;
  logic [7:0] wdata;

  modport master (
    output rvalid, raddr, rdata, done, wgnt,
    input  busy, dump_done, wreq, wdata
  );

  modport slave (
    input  rvalid, raddr, rdata, done, wgnt,
    output busy, dump_done, wreq, wdata
  );
endinterface

// File: rtl/sector_hexdump.sv
// sector_hexdump
//   Captures one 512-byte sector into a local buffer and, on the reader's done
//   pulse, streams it as 32 lines of ASCII hex dump:
//     "OOO: HH HH ... HH \r\n"  (3-digit offset, 16 byte groups)
//   Ports: clk, rst_n (async, active-low), bus (sector_hexdump_if.slave).
//   Parameters: UPPER_HEX   1 = A-F, 0 = a-f
//               TRAIL_BLANK 1 = one extra CR LF after the last line
//
// state | meaning
// IDLE  | buffer accepts writes, waiting for done
// OFS2  | offset digit 2 (line bit 4)
// OFS1  | offset digit 1 (line bits 3:0)
// OFS0  | offset digit 0, always '0'
// COLON | ':'
// SPC   | ' ' after the colon
// RD    | buffer read of {line, byte}, no output
// HI    | high nibble of the read byte
// LO    | low nibble of the read byte
// SEP   | ' ' after a byte group
// CR    | end of line CR
// LF    | end of line LF
// TCR   | trailing blank line CR
// TLF   | trailing blank line LF
module sector_hexdump #(
  parameter bit UPPER_HEX   = 1'b1,
  parameter bit TRAIL_BLANK = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  sector_hexdump_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_OFS2, S_OFS1, S_OFS0, S_COLON, S_SPC, S_RD,
    S_HI, S_LO, S_SEP, S_CR, S_LF, S_TCR, S_TLF
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] line_q, line_d;
  logic [3:0] byte_q, byte_d;
  logic       dump_done_q;
  logic [7:0] rbyte_q;
  logic [7:0] mem_q [512];

  logic       wreq_c;
  logic [7:0] wdata_c;
  logic       fin_c;
  logic       rd_en_c;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
  endfunction

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    byte_d  = byte_q;
    wreq_c  = 1'b0;
    wdata_c = 8'h00;
    fin_c   = 1'b0;
    rd_en_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.done) begin
          state_d = S_OFS2;
          line_d  = 5'd0;
          byte_d  = 4'd0;
        end
      end
      S_OFS2: begin
        wreq_c  = 1'b1;
        wdata_c = hex_char({3'b000, line_q[4]});
        if (bus.wgnt) state_d = S_OFS1;
      end
      S_OFS1: begin
        wreq_c  = 1'b1;
        wdata_c = hex_char(line_q[3:0]);
        if (bus.wgnt) state_d = S_OFS0;
      end
      S_OFS0: begin
        wreq_c  = 1'b1;
        wdata_c = 8'h30;
        if (bus.wgnt) state_d = S_COLON;
      end
      S_COLON: begin
        wreq_c  = 1'b1;
        wdata_c = 8'h3A;
        if (bus.wgnt) state_d = S_SPC;
      end
      S_SPC: begin
        wreq_c  = 1'b1;
        wdata_c = 8'h20;
        if (bus.wgnt) state_d = S_RD;
      end
      S_RD: begin
        rd_en_c = 1'b1;
        state_d = S_HI;
      end
      S_HI: begin
        wreq_c  = 1'b1;
        wdata_c = hex_char(rbyte_q[7:4]);
        if (bus.wgnt) state_d = S_LO;
      end
      S_LO: begin
        wreq_c  = 1'b1;
        wdata_c = hex_char(rbyte_q[3:0]);
        if (bus.wgnt) state_d = S_SEP;
      end
      S_SEP: begin
        wreq_c  = 1'b1;
        wdata_c = 8'h20;
        if (bus.wgnt) begin
          if (byte_q != 4'd15) begin
            byte_d  = byte_q + 4'd1;
            state_d = S_RD;
          end else begin
            byte_d  = 4'd0;
            state_d = S_CR;
          end
        end
      end
      S_CR: begin
        wreq_c  = 1'b1;
        wdata_c = 8'h0D;
        if (bus.wgnt) state_d = S_LF;
      end
      S_LF: begin
        wreq_c  = 1'b1;
        wdata_c = 8'h0A;
        if (bus.wgnt) begin
          if (line_q != 5'd31) begin
            line_d  = line_q + 5'd1;
            state_d = S_OFS2;
          end else if (TRAIL_BLANK) begin
            state_d = S_TCR;
          end else begin
            state_d = S_IDLE;
            fin_c   = 1'b1;
          end
        end
      end
      S_TCR: begin
        wreq_c  = 1'b1;
        wdata_c = 8'h0D;
        if (bus.wgnt) state_d = S_TLF;
      end
      S_TLF: begin
        wreq_c  = 1'b1;
        wdata_c = 8'h0A;
        if (bus.wgnt) begin
          state_d = S_IDLE;
          fin_c   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      line_q      <= 5'd0;
      byte_q      <= 4'd0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      byte_q      <= byte_d;
      dump_done_q <= fin_c;
    end
  end

  // Buffer is deliberately not reset; writes are only taken while idle so a
  // sector being dumped cannot be overwritten underneath the dump.
  always_ff @(posedge clk) begin
    if (bus.rvalid && (state_q == S_IDLE)) mem_q[bus.raddr] <= bus.rdata;
    if (rd_en_c) rbyte_q <= mem_q[{line_q, byte_q}];
  end

  // wreq/wdata are decoded from registered state only, so they hold steady
  // while waiting for a grant and drop immediately on async reset.
  assign bus.wreq      = wreq_c;
  assign bus.wdata     = wdata_c;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.dump_done = dump_done_q;

endmodule

// File: tb/tb_sector_hexdump.sv
module tb_sector_hexdump;
  typedef logic [7:0] u8_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       rvalid = 1'b0;
  logic [8:0] raddr  = '0;
  logic [7:0] rdata  = '0;
  logic       done   = 1'b0;
  logic       gnt_a  = 1'b1;
  logic       gnt_b  = 1'b1;
  logic       bp_en  = 1'b0;

  sector_hexdump_if ifa();
  sector_hexdump_if ifb();

  assign ifa.rvalid = rvalid;
  assign ifa.raddr  = raddr;
  assign ifa.rdata  = rdata;
  assign ifa.done   = done;
  assign ifa.wgnt   = gnt_a;
  assign ifb.rvalid = rvalid;
  assign ifb.raddr  = raddr;
  assign ifb.rdata  = rdata;
  assign ifb.done   = done;
  assign ifb.wgnt   = gnt_b;

  sector_hexdump #(.UPPER_HEX(1'b1), .TRAIL_BLANK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  sector_hexdump #(.UPPER_HEX(1'b0), .TRAIL_BLANK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_chk = 0;
  int n_fail = 0;

  u8_t mdl_mem [512];

  // grant generator: constant or ~30% random, changed away from the edge
  always @(posedge clk) begin
    #2;
    gnt_a <= bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    gnt_b <= bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitors
  logic mon_clr = 1'b0;
  u8_t  cap_a[$], cap_b[$];
  int   dd_cnt_a, dd_cyc_a, gr_cyc_a, busy_cnt_a, stab_a;
  int   dd_cnt_b, dd_cyc_b, gr_cyc_b, busy_cnt_b, stab_b;
  logic prev_wait_a = 1'b0, prev_wait_b = 1'b0;
  u8_t  prev_data_a, prev_data_b;

  always @(negedge clk) begin
    if (mon_clr) begin
      cap_a.delete();
      dd_cnt_a <= 0; dd_cyc_a <= -1; gr_cyc_a <= -1; busy_cnt_a <= 0; stab_a <= 0;
    end else if (rst_n) begin
      if (ifa.wreq && ifa.wgnt) begin
        cap_a.push_back(ifa.wdata);
        gr_cyc_a <= cyc;
      end
      if (ifa.dump_done) begin
        dd_cnt_a <= dd_cnt_a + 1;
        dd_cyc_a <= cyc;
      end
      if (ifa.busy) busy_cnt_a <= busy_cnt_a + 1;
      if (prev_wait_a && ifa.wreq && (ifa.wdata !== prev_data_a)) stab_a <= stab_a + 1;
    end
    prev_wait_a <= rst_n && ifa.wreq && !ifa.wgnt;
    prev_data_a <= ifa.wdata;
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      cap_b.delete();
      dd_cnt_b <= 0; dd_cyc_b <= -1; gr_cyc_b <= -1; busy_cnt_b <= 0; stab_b <= 0;
    end else if (rst_n) begin
      if (ifb.wreq && ifb.wgnt) begin
        cap_b.push_back(ifb.wdata);
        gr_cyc_b <= cyc;
      end
      if (ifb.dump_done) begin
        dd_cnt_b <= dd_cnt_b + 1;
        dd_cyc_b <= cyc;
      end
      if (ifb.busy) busy_cnt_b <= busy_cnt_b + 1;
      if (prev_wait_b && ifb.wreq && (ifb.wdata !== prev_data_b)) stab_b <= stab_b + 1;
    end
    prev_wait_b <= rst_n && ifb.wreq && !ifb.wgnt;
    prev_data_b <= ifb.wdata;
  end

  // reference: dump text built straight from the line format with printf
  function automatic void build_exp(input bit upper, input bit trail, output u8_t q[$]);
    string s;
    q.delete();
    for (int l = 0; l < 32; l++) begin
      s = $sformatf("%03x: ", l * 16);
      for (int b = 0; b < 16; b++) s = {s, $sformatf("%02x ", mdl_mem[l * 16 + b])};
      if (upper) s = s.toupper();
      for (int i = 0; i < s.len(); i++) q.push_back(u8_t'(s[i]));
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    if (trail) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
  endfunction

  function automatic int diff_q(input u8_t a[$], input u8_t b[$]);
    int n = 0;
    int m = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < m; i++) if (a[i] !== b[i]) n++;
    n += (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    return n;
  endfunction

  function automatic int diff_str(input u8_t q[$], input int pos, input string s);
    int n = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (pos + i >= q.size()) n++;
      else if (q[pos + i] !== u8_t'(s[i])) n++;
    end
    return n;
  endfunction

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #2;
      rvalid = 1'b1;
      raddr  = 9'(i);
      rdata  = rnd ? 8'($urandom) : 8'(i);
      mdl_mem[i] = rdata;
    end
    @(posedge clk); #2;
    rvalid = 1'b0;
  endtask

  task automatic start_dump();
    clear_mon();
    @(posedge clk); #2 done = 1'b1;
    @(posedge clk); #2 done = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!ifa.busy && !ifb.busy) begin
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 0", ifa.busy); end
    n_chk++; if (ifa.wreq !== 1'b0) begin n_fail++; $display("FAIL reset_wreq_a: got %b expected 0", ifa.wreq); end
    n_chk++; if (ifa.wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata_a: got %h expected 00", ifa.wdata); end
    n_chk++; if (ifa.dump_done !== 1'b0) begin n_fail++; $display("FAIL reset_dd_a: got %b expected 0", ifa.dump_done); end
    n_chk++; if (ifb.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b expected 0", ifb.busy); end
    n_chk++; if (ifb.wreq !== 1'b0) begin n_fail++; $display("FAIL reset_wreq_b: got %b expected 0", ifb.wreq); end
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (ifa.wreq !== 1'b0 || ifb.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got wreq_a=%b busy_b=%b expected 0 0", ifa.wreq, ifb.busy); end
  endtask

  task automatic test_const_dump();
    u8_t ea[$], eb[$];
    bit to;
    fill(1'b0);
    build_exp(1'b1, 1'b1, ea);
    build_exp(1'b0, 1'b0, eb);
    bp_en = 1'b0;
    start_dump();
    @(negedge clk);
    n_chk++; if (ifa.wreq !== 1'b1 || ifa.wdata !== 8'h30 || ifa.busy !== 1'b1) begin
      n_fail++; $display("FAIL latency_a: got wreq=%b wdata=%h busy=%b expected 1 30 1", ifa.wreq, ifa.wdata, ifa.busy); end
    n_chk++; if (ifb.wreq !== 1'b1 || ifb.wdata !== 8'h30 || ifb.busy !== 1'b1) begin
      n_fail++; $display("FAIL latency_b: got wreq=%b wdata=%h busy=%b expected 1 30 1", ifb.wreq, ifb.wdata, ifb.busy); end
    wait_idle(to);
    n_chk++; if (to) begin n_fail++; $display("FAIL const_timeout: got timeout expected idle"); end
    n_chk++; if (cap_a.size() != 1762) begin n_fail++; $display("FAIL len_a: got %0d expected 1762", cap_a.size()); end
    n_chk++; if (cap_b.size() != 1760) begin n_fail++; $display("FAIL len_b: got %0d expected 1760", cap_b.size()); end
    n_chk++; if (diff_q(cap_a, ea) != 0) begin n_fail++; $display("FAIL text_a: got %0d differing chars expected 0", diff_q(cap_a, ea)); end
    n_chk++; if (diff_q(cap_b, eb) != 0) begin n_fail++; $display("FAIL text_b: got %0d differing chars expected 0", diff_q(cap_b, eb)); end
    n_chk++; if (diff_str(cap_a, 0, "000: 00 01 02") != 0) begin n_fail++; $display("FAIL line0_a: got %0d bad chars expected 0", diff_str(cap_a, 0, "000: 00 01 02")); end
    n_chk++; if (diff_str(cap_a, 1705, "1F0: F0 F1") != 0) begin n_fail++; $display("FAIL line31_a: got %0d bad chars expected 0", diff_str(cap_a, 1705, "1F0: F0 F1")); end
    n_chk++; if (diff_str(cap_b, 35, "0a 0b 0c 0d 0e 0f") != 0) begin n_fail++; $display("FAIL lower_b: got %0d bad chars expected 0", diff_str(cap_b, 35, "0a 0b 0c 0d 0e 0f")); end
    n_chk++; if (cap_b.size() == 0 || cap_b[cap_b.size() - 1] !== 8'h0A) begin n_fail++; $display("FAIL last_b: got size %0d expected last char 0A", cap_b.size()); end
    n_chk++; if (dd_cnt_a != 1 || dd_cyc_a != gr_cyc_a + 1) begin n_fail++; $display("FAIL dd_a: got count=%0d at %0d expected 1 at %0d", dd_cnt_a, dd_cyc_a, gr_cyc_a + 1); end
    n_chk++; if (dd_cnt_b != 1 || dd_cyc_b != gr_cyc_b + 1) begin n_fail++; $display("FAIL dd_b: got count=%0d at %0d expected 1 at %0d", dd_cnt_b, dd_cyc_b, gr_cyc_b + 1); end
    n_chk++; if (busy_cnt_a != 2274) begin n_fail++; $display("FAIL busy_len_a: got %0d expected 2274", busy_cnt_a); end
    n_chk++; if (busy_cnt_b != 2272) begin n_fail++; $display("FAIL busy_len_b: got %0d expected 2272", busy_cnt_b); end
  endtask

  task automatic test_backpressure(input bit rnd_fill);
    u8_t ea[$], eb[$];
    bit to;
    if (rnd_fill) fill(1'b1);
    build_exp(1'b1, 1'b1, ea);
    build_exp(1'b0, 1'b0, eb);
    bp_en = 1'b1;
    start_dump();
    wait_idle(to);
    bp_en = 1'b0;
    n_chk++; if (to) begin n_fail++; $display("FAIL bp_timeout: got timeout expected idle"); end
    n_chk++; if (stab_a != 0 || stab_b != 0) begin n_fail++; $display("FAIL bp_stable: got %0d/%0d changes expected 0", stab_a, stab_b); end
    n_chk++; if (diff_q(cap_a, ea) != 0) begin n_fail++; $display("FAIL bp_text_a: got %0d differing chars expected 0", diff_q(cap_a, ea)); end
    n_chk++; if (diff_q(cap_b, eb) != 0) begin n_fail++; $display("FAIL bp_text_b: got %0d differing chars expected 0", diff_q(cap_b, eb)); end
    n_chk++; if (dd_cnt_a != 1 || dd_cnt_b != 1) begin n_fail++; $display("FAIL bp_dd: got %0d/%0d pulses expected 1/1", dd_cnt_a, dd_cnt_b); end
  endtask

  task automatic test_busy_write();
    u8_t ea[$], eb[$];
    bit to;
    build_exp(1'b1, 1'b1, ea);
    build_exp(1'b0, 1'b0, eb);
    bp_en = 1'b0;
    start_dump();
    repeat (60) @(posedge clk);
    #2;
    rvalid = 1'b1; raddr = 9'd0; rdata = 8'hAA; done = 1'b1;
    @(posedge clk); #2;
    rvalid = 1'b0; done = 1'b0;
    wait_idle(to);
    n_chk++; if (to) begin n_fail++; $display("FAIL busy_timeout: got timeout expected idle"); end
    n_chk++; if (cap_a.size() != 1762 || dd_cnt_a != 1) begin n_fail++; $display("FAIL second_done_a: got len=%0d pulses=%0d expected 1762 1", cap_a.size(), dd_cnt_a); end
    start_dump();
    wait_idle(to);
    n_chk++; if (diff_str(cap_a, 5, "00 01") != 0) begin n_fail++; $display("FAIL busy_write_a: got %0d bad chars expected 0", diff_str(cap_a, 5, "00 01")); end
    n_chk++; if (diff_q(cap_a, ea) != 0 || diff_q(cap_b, eb) != 0) begin n_fail++; $display("FAIL busy_write_text: got %0d/%0d diffs expected 0/0", diff_q(cap_a, ea), diff_q(cap_b, eb)); end
  endtask

  task automatic test_reset_mid();
    u8_t ea[$];
    bit to;
    build_exp(1'b1, 1'b1, ea);
    bp_en = 1'b0;
    start_dump();
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cap_a.size() >= 100) begin to = 1'b0; break; end
    end
    n_chk++; if (to) begin n_fail++; $display("FAIL mid_timeout: got %0d chars expected 100", cap_a.size()); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (ifa.wreq !== 1'b0 || ifa.busy !== 1'b0 || ifb.wreq !== 1'b0 || ifb.busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got wreq=%b%b busy=%b%b expected 00 00", ifa.wreq, ifb.wreq, ifa.busy, ifb.busy); end
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (ifa.wreq !== 1'b0 || ifa.busy !== 1'b0) begin n_fail++; $display("FAIL no_resume: got wreq=%b busy=%b expected 0 0", ifa.wreq, ifa.busy); end
    start_dump();
    wait_idle(to);
    n_chk++; if (diff_str(cap_a, 0, "000: ") != 0) begin n_fail++; $display("FAIL restart_a: got %0d bad chars expected 0", diff_str(cap_a, 0, "000: ")); end
    n_chk++; if (diff_q(cap_a, ea) != 0) begin n_fail++; $display("FAIL restart_text_a: got %0d diffs expected 0", diff_q(cap_a, ea)); end
  endtask

  task automatic test_simul();
    u8_t ea[$], eb[$];
    bit to;
    clear_mon();
    @(posedge clk); #2;
    rvalid = 1'b1; raddr = 9'd511; rdata = 8'h5A; done = 1'b1;
    mdl_mem[511] = 8'h5A;
    @(posedge clk); #2;
    rvalid = 1'b0; done = 1'b0;
    build_exp(1'b1, 1'b1, ea);
    build_exp(1'b0, 1'b0, eb);
    wait_idle(to);
    n_chk++; if (to) begin n_fail++; $display("FAIL simul_timeout: got timeout expected idle"); end
    n_chk++; if (diff_str(cap_a, 1755, "5A \r") > 1) begin n_fail++; $display("FAIL simul_a: got %0d bad chars expected 0", diff_str(cap_a, 1755, "5A ")); end
    n_chk++; if (diff_str(cap_b, 1755, "5a ") != 0) begin n_fail++; $display("FAIL simul_b: got %0d bad chars expected 0", diff_str(cap_b, 1755, "5a ")); end
    n_chk++; if (diff_q(cap_a, ea) != 0 || diff_q(cap_b, eb) != 0) begin n_fail++; $display("FAIL simul_text: got %0d/%0d diffs expected 0/0", diff_q(cap_a, ea), diff_q(cap_b, eb)); end
  endtask

  initial begin
    test_reset();
    test_const_dump();
    test_backpressure(1'b0);
    test_busy_write();
    test_reset_mid();
    test_simul();
    test_backpressure(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sector_hexdump.md
Name: sector_hexdump

Overview:
- Sits directly downstream of sd_spi_sector_reader and upstream of uart_tx.
- Captures one 512-byte sector from the reader's rvalid/raddr/rdata stream into an internal buffer.
- On the reader's done pulse, streams the sector as an ASCII hex dump over a wreq/wgnt byte handshake for the UART.
- The buffer decouples the fast SPI byte rate from the slow UART rate; busy lets the top hold off the next sector read.

Parameters:
UPPER_HEX, 1, 1 = hex digits A-F upper-case (0x41..0x46); 0 = a-f lower-case (0x61..0x66)
TRAIL_BLANK, 1, 1 = emit one extra CR LF after line 31; 0 = none

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
rvalid  in  1  sector byte valid (from reader)
raddr  in  9  byte offset 0..511 within sector
rdata  in  8  sector byte
done  in  1  one-cycle pulse: sector read complete
busy  out  1  high from done acceptance until dump finished
dump_done  out  1  one-cycle pulse when the last character is granted
wreq  out  1  output character valid
wgnt  in  1  sink accepts character
wdata  out  8  ASCII character

Behaviour:
- Reset (async): state=IDLE; busy=0, dump_done=0, wreq=0, wdata=0x00; line counter=0, byte counter=0. Buffer contents are not cleared.
- Buffer: 512x8, synchronous write, 1-cycle synchronous read.
- Write mem[raddr]=rdata whenever rvalid=1 and state=IDLE. rvalid while busy is ignored (no write).
- Line format, 32 lines (L=0..31), 55 characters each:
  - 3 upper/lower hex digits of offset L*16 (000..1F0)
  - ':' ' '
  - 16 groups of {hi nibble, lo nibble, ' '}
  - CR (0x0D), LF (0x0A)
  - Total 1760 characters, plus 2 if TRAIL_BLANK=1.
- States: IDLE, OFS2, OFS1, OFS0, COLON, SPC, RD, HI, LO, SEP, CR, LF, TCR, TLF.
- IDLE: done=1 -> OFS2, busy=1, counters cleared. done while busy is ignored. Simultaneous rvalid and done in IDLE: the write occurs and the dump starts.
- Output states (all except IDLE and RD) drive wreq=1 with wdata for that state.
  - wdata is stable while wreq=1 and wgnt=0.
  - The state advances only in a cycle with wreq&wgnt. Exactly one character is transferred per grant.
- Transitions:
  - OFS2->OFS1->OFS0->COLON->SPC->RD.
  - RD: wreq=0, memory read of address {L,byte}, 1 cycle -> HI. The read byte is latched for HI/LO.
  - HI->LO->SEP.
  - SEP: if byte<15, byte++ and ->RD; else ->CR.
  - CR->LF.
  - LF: if L<31, L++ and ->OFS2; else ->TCR if TRAIL_BLANK, else finish.
  - TCR->TLF->finish.
- Finish (on the final grant): next cycle state=IDLE, busy=0, wreq=0, dump_done=1 for exactly one cycle.
- Latency: done sampled high in cycle N -> cycle N+1 wreq=1, wdata=0x30 ('0'), busy=1.
- Minimum dump time with wgnt tied high: 1760 output cycles + 512 RD cycles (+2 with TRAIL_BLANK).
- Reset mid-dump: immediate return to IDLE with wreq=0. No resume; a new done restarts from line 0.

Test Plan:
- Fill mem[i]=i[7:0] for i=0..511, pulse done, wgnt=1 constant -> first 55 chars "000: 00 01 02 ... 0F \r\n"; line 31 starts "1F0: F0 F1"; 1762 chars total; dump_done one cycle after the final LF grant.
- Same fill, UPPER_HEX=0, TRAIL_BLANK=0 -> line 0 contains "0a 0b 0c 0d 0e 0f"; exactly 1760 chars; last char 0x0A.
- Random wgnt backpressure (~30% high) -> wdata never changes while wreq=1&wgnt=0; captured text identical to the constant-wgnt run.
- rvalid pulses with raddr=0, rdata=0xAA while busy -> buffer unchanged; the next dump shows the original byte 0x00 at offset 000. A second done during the dump is ignored.
- Assert rst_n=0 after 100 characters -> wreq=0 and busy=0 asynchronously. After release and a new done -> output restarts with "000: ".
- rvalid and done in the same IDLE cycle with raddr=511, rdata=0x5A -> last group on line 31 reads "5A".
